// File: rtl/mem_writeback_if.sv
// Writeback bus: execute/memory-stage inputs, memory read return and
// register-file write outputs.
interface mem_writeback_if #(
    parameter int DATA_W  = 32,
    parameter int HALF_W  = 16,
    parameter int RADDR_W = 4
);
    logic [DATA_W-1:0]  data_calc_i;
    logic               mem_to_reg_i;
    logic               ld_half_i;
    logic               ld_signed_i;
    logic [RADDR_W-1:0] rf_wr_select_i;
    logic               rf_wr_en_i;
    logic [HALF_W-1:0]  mem_rdata_i;
    logic               mem_rvalid_i;
    logic [DATA_W-1:0]  rf_wr_data_o;
    logic [RADDR_W-1:0] rf_wr_addr_o;
    logic               rf_wr_en_o;
    logic               stall_o;
    logic               err_timeout_o;

    modport master (
        output data_calc_i, mem_to_reg_i, ld_half_i, ld_signed_i,
        output rf_wr_select_i, rf_wr_en_i, mem_rdata_i, mem_rvalid_i,
        input  rf_wr_data_o, rf_wr_addr_o, rf_wr_en_o, stall_o,
        input  err_timeout_o
    );

    modport slave (
        input  data_calc_i, mem_to_reg_i, ld_half_i, ld_signed_i,
        input  rf_wr_select_i, rf_wr_en_i, mem_rdata_i, mem_rvalid_i,
        output rf_wr_data_o, rf_wr_addr_o, rf_wr_en_o, stall_o,
        output err_timeout_o
    );
endinterface

// File: rtl/mem_writeback.sv
// Writeback stage: retires ALU results and assembles two-halfword loads,
// stalling upstream while a load is outstanding.
module mem_writeback #(
    parameter int DATA_W  = 32,
    parameter int HALF_W  = 16,
    parameter int RADDR_W = 4,
    parameter int TIMEOUT = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mem_writeback_if.slave wb
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LO,
        WAIT_HI
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [HALF_W-1:0]  lo_q;
    logic [RADDR_W-1:0] addr_q;
    logic               half_q;
    logic               signed_q;
    logic [DATA_W-1:0]  wr_data_q;
    logic [RADDR_W-1:0] wr_addr_q;
    logic               wr_en_q;
    logic               err_q;

    logic [HALF_W-1:0]  ext;

    assign ext = {HALF_W{signed_q & wb.mem_rdata_i[HALF_W-1]}};

    assign wb.rf_wr_data_o  = wr_data_q;
    assign wb.rf_wr_addr_o  = wr_addr_q;
    assign wb.rf_wr_en_o    = wr_en_q;
    assign wb.stall_o       = (state_q != IDLE);
    assign wb.err_timeout_o = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lo_q      <= '0;
            addr_q    <= '0;
            half_q    <= 1'b0;
            signed_q  <= 1'b0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
            wr_en_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (wb.rf_wr_en_i) begin
                        if (wb.mem_to_reg_i) begin
                            addr_q   <= wb.rf_wr_select_i;
                            half_q   <= wb.ld_half_i;
                            signed_q <= wb.ld_signed_i;
                            cnt_q    <= '0;
                            state_q  <= WAIT_LO;
                        end else begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= wb.data_calc_i;
                            wr_addr_q <= wb.rf_wr_select_i;
                        end
                    end
                end
                WAIT_LO: begin
                    if (wb.mem_rvalid_i) begin
                        lo_q <= wb.mem_rdata_i;
                        if (half_q) begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= {ext, wb.mem_rdata_i};
                            wr_addr_q <= addr_q;
                            state_q   <= IDLE;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= WAIT_HI;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (wb.mem_rvalid_i) begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= {wb.mem_rdata_i, lo_q};
                        wr_addr_q <= addr_q;
                        state_q   <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_writeback.sv
// Directed bench for mem_writeback: ALU writes, word/half loads,
// timeout, async reset mid-load and stray rvalid.
module tb_mem_writeback;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    mem_writeback_if #(.DATA_W(32), .HALF_W(16), .RADDR_W(4)) wb ();

    mem_writeback #(
        .DATA_W (32),
        .HALF_W (16),
        .RADDR_W(4),
        .TIMEOUT(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .wb   (wb.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic en,
                          input logic [31:0] d, input logic [3:0] a);
        chk({tag, "_en"}, 32'(wb.rf_wr_en_o), 32'(en));
        chk({tag, "_data"}, wb.rf_wr_data_o, d);
        chk({tag, "_addr"}, 32'(wb.rf_wr_addr_o), 32'(a));
    endtask

    initial begin
        wb.data_calc_i    = '0;
        wb.mem_to_reg_i   = 1'b0;
        wb.ld_half_i      = 1'b0;
        wb.ld_signed_i    = 1'b0;
        wb.rf_wr_select_i = '0;
        wb.rf_wr_en_i     = 1'b0;
        wb.mem_rdata_i    = '0;
        wb.mem_rvalid_i   = 1'b0;

        // Reset state
        tick();
        tick();
        chk_wr("rst", 1'b0, 32'h0, 4'd0);
        chk("rst_stall", 32'(wb.stall_o), 32'd0);
        chk("rst_err", 32'(wb.err_timeout_o), 32'd0);
        rst = 1'b0;

        // 1: ALU write
        wb.rf_wr_en_i     = 1'b1;
        wb.data_calc_i    = 32'hDEADBEEF;
        wb.rf_wr_select_i = 4'd5;
        tick();
        chk_wr("alu", 1'b1, 32'hDEADBEEF, 4'd5);
        chk("alu_stall", 32'(wb.stall_o), 32'd0);
        wb.rf_wr_en_i = 1'b0;
        tick();
        chk_wr("alu_after", 1'b0, 32'hDEADBEEF, 4'd5);

        // 2: word load to r3
        wb.rf_wr_en_i     = 1'b1;
        wb.mem_to_reg_i   = 1'b1;
        wb.rf_wr_select_i = 4'd3;
        wb.data_calc_i    = 32'h0BADF00D;
        tick();
        chk("wl_stall0", 32'(wb.stall_o), 32'd1);
        chk("wl_en0", 32'(wb.rf_wr_en_o), 32'd0);
        wb.rf_wr_en_i   = 1'b0;
        wb.mem_rvalid_i = 1'b1;
        wb.mem_rdata_i  = 16'h5678;
        tick();
        chk("wl_stall1", 32'(wb.stall_o), 32'd1);
        chk("wl_en1", 32'(wb.rf_wr_en_o), 32'd0);
        wb.mem_rvalid_i = 1'b0;
        tick();
        chk("wl_stall2", 32'(wb.stall_o), 32'd1);
        wb.mem_rvalid_i = 1'b1;
        wb.mem_rdata_i  = 16'h1234;
        tick();
        chk_wr("wl", 1'b1, 32'h12345678, 4'd3);
        chk("wl_stall3", 32'(wb.stall_o), 32'd0);
        wb.mem_rvalid_i = 1'b0;
        tick();
        chk("wl_en_after", 32'(wb.rf_wr_en_o), 32'd0);

        // 3: signed half load
        wb.rf_wr_en_i     = 1'b1;
        wb.mem_to_reg_i   = 1'b1;
        wb.ld_half_i      = 1'b1;
        wb.ld_signed_i    = 1'b1;
        wb.rf_wr_select_i = 4'd7;
        tick();
        chk("hs_stall", 32'(wb.stall_o), 32'd1);
        wb.rf_wr_en_i   = 1'b0;
        wb.mem_rvalid_i = 1'b1;
        wb.mem_rdata_i  = 16'h8001;
        tick();
        chk_wr("hs", 1'b1, 32'hFFFF8001, 4'd7);
        chk("hs_stall1", 32'(wb.stall_o), 32'd0);
        wb.mem_rvalid_i = 1'b0;

        // 3b: unsigned half load
        wb.rf_wr_en_i     = 1'b1;
        wb.ld_signed_i    = 1'b0;
        wb.rf_wr_select_i = 4'd8;
        tick();
        wb.rf_wr_en_i   = 1'b0;
        wb.mem_rvalid_i = 1'b1;
        tick();
        chk_wr("hu", 1'b1, 32'h00008001, 4'd8);
        chk("hu_stall", 32'(wb.stall_o), 32'd0);
        wb.mem_rvalid_i = 1'b0;
        wb.ld_half_i    = 1'b0;

        // 4: timeout with no rvalid (TIMEOUT=4)
        wb.rf_wr_en_i     = 1'b1;
        wb.rf_wr_select_i = 4'd9;
        tick();
        wb.rf_wr_en_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("to_stall%0d", i), 32'(wb.stall_o), 32'd1);
            chk($sformatf("to_err%0d", i), 32'(wb.err_timeout_o), 32'd0);
        end
        tick();
        chk("to_err", 32'(wb.err_timeout_o), 32'd1);
        chk("to_stall", 32'(wb.stall_o), 32'd0);
        chk_wr("to_nowr", 1'b0, 32'h00008001, 4'd8);
        tick();
        chk("to_sticky", 32'(wb.err_timeout_o), 32'd1);

        // 4b: rvalid on the last allowed cycle wins
        rst = 1'b1;
        #1;
        chk("to_clr", 32'(wb.err_timeout_o), 32'd0);
        tick();
        rst = 1'b0;
        wb.rf_wr_en_i     = 1'b1;
        wb.rf_wr_select_i = 4'd10;
        tick();
        wb.rf_wr_en_i = 1'b0;
        tick();
        tick();
        tick();
        wb.mem_rvalid_i = 1'b1;
        wb.mem_rdata_i  = 16'hAAAA;
        tick();
        chk("edge_stall", 32'(wb.stall_o), 32'd1);
        chk("edge_err", 32'(wb.err_timeout_o), 32'd0);
        wb.mem_rdata_i = 16'hBBBB;
        tick();
        chk_wr("edge", 1'b1, 32'hBBBBAAAA, 4'd10);
        chk("edge_err2", 32'(wb.err_timeout_o), 32'd0);
        wb.mem_rvalid_i = 1'b0;

        // 5: async reset in WAIT_HI
        wb.rf_wr_en_i     = 1'b1;
        wb.rf_wr_select_i = 4'd11;
        tick();
        wb.rf_wr_en_i   = 1'b0;
        wb.mem_rvalid_i = 1'b1;
        wb.mem_rdata_i  = 16'h1111;
        tick();
        chk("rm_stall", 32'(wb.stall_o), 32'd1);
        wb.mem_rvalid_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_wr("rm", 1'b0, 32'h0, 4'd0);
        chk("rm_stall0", 32'(wb.stall_o), 32'd0);
        tick();
        rst = 1'b0;
        wb.mem_rvalid_i = 1'b1;
        wb.mem_rdata_i  = 16'h2222;
        tick();
        chk("rm_late0", 32'(wb.rf_wr_en_o), 32'd0);
        tick();
        chk("rm_late1", 32'(wb.rf_wr_en_o), 32'd0);
        chk("rm_stall1", 32'(wb.stall_o), 32'd0);

        // 6: stray rvalid in IDLE plus back-to-back ALU writes
        wb.mem_to_reg_i = 1'b0;
        wb.rf_wr_en_i   = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wb.rf_wr_select_i = 4'(i);
            wb.data_calc_i    = 32'h11111111 * 32'(i);
            tick();
            chk_wr($sformatf("b2b%0d", i), 1'b1,
                   32'h11111111 * 32'(i), 4'(i));
            chk($sformatf("b2b_stall%0d", i), 32'(wb.stall_o), 32'd0);
        end
        wb.rf_wr_en_i   = 1'b0;
        wb.mem_rvalid_i = 1'b0;
        tick();
        chk_wr("b2b_end", 1'b0, 32'h44444444, 4'd4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end
endmodule
